// File: rtl/vga_pattern_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_pattern_gen_if
// Description : Pixel-side bundle between vga_sync and vga_pattern_gen.
//               Carries the raster position, syncs and mode button in, and the
//               coloured pixel stream, delayed syncs and status back out.
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_pattern_gen_if #(
    parameter int COLOR_BITS = 1,
    parameter int CNT_W      = 10
);
    logic [CNT_W-1:0]      h_count;
    logic [CNT_W-1:0]      v_count;
    logic                  display_en;
    logic                  h_sync_in;
    logic                  v_sync_in;
    logic                  button;
    logic [COLOR_BITS-1:0] r;
    logic [COLOR_BITS-1:0] g;
    logic [COLOR_BITS-1:0] b;
    logic                  h_sync;
    logic                  v_sync;
    logic [2:0]            mode;
    logic [15:0]           frame_cnt;

    // Raster source / pixel sink side
    modport master (
        output h_count, v_count, display_en, h_sync_in, v_sync_in, button,
        input  r, g, b, h_sync, v_sync, mode, frame_cnt
    );

    // Pattern generator side
    modport slave (
        input  h_count, v_count, display_en, h_sync_in, v_sync_in, button,
        output r, g, b, h_sync, v_sync, mode, frame_cnt
    );
endinterface
`default_nettype wire

// File: rtl/vga_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_pattern_gen
// Description : VGA test-pattern generator. Two-stage pipeline from raster
//               counts to registered RGB, with syncs delayed to match.
//               Patterns: colour bars, checkerboard, gradient, bouncing box,
//               solid white. Button advances the mode on frame boundaries.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_pattern_gen #(
    parameter int COLOR_BITS = 1,
    parameter int CNT_W      = 10,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int CHECK_LOG2 = 5,
    parameter int BOX_SIZE   = 64,
    parameter int BOX_STEP   = 2
) (
    input  wire              clk_sys,
    input  wire              reset,
    vga_pattern_gen_if.slave bus
);
    // Box arithmetic carries one extra bit so position+step+size never wraps
    localparam int                BW          = CNT_W + 1;
    localparam logic [BW-1:0]     c_h_active  = BW'(H_ACTIVE);
    localparam logic [BW-1:0]     c_v_active  = BW'(V_ACTIVE);
    localparam logic [BW-1:0]     c_box_size  = BW'(BOX_SIZE);
    localparam logic [BW-1:0]     c_box_step  = BW'(BOX_STEP);
    localparam logic [BW-1:0]     c_h_limit   = BW'(H_ACTIVE - BOX_SIZE);
    localparam logic [BW-1:0]     c_v_limit   = BW'(V_ACTIVE - BOX_SIZE);
    localparam logic [CNT_W-1:0]  c_bar_w     = CNT_W'(H_ACTIVE / 8);
    localparam logic [CNT_W-1:0]  c_tick_line = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0]  c_last_bar  = CNT_W'(7);
    localparam logic [2:0]        c_mode_last = 3'd4;
    localparam logic [COLOR_BITS-1:0] c_full  = {COLOR_BITS{1'b1}};

    // Stage-1 registers
    logic [CNT_W-1:0]      h1_q, v1_q;
    logic                  de1_q, hs1_q, vs1_q;
    // Stage-2 registers
    logic [COLOR_BITS-1:0] r_q, g_q, b_q;
    logic                  hs2_q, vs2_q;
    // Button synchroniser and edge detector
    logic                  btn_meta_q, btn_sync_q, btn_prev_q;
    logic                  w_btn_rise;
    // Frame-rate control state
    logic [2:0]            mode_q, mode_d;
    logic                  pending_q, pending_d;
    logic [15:0]           frame_cnt_q, frame_cnt_d;
    logic [BW-1:0]         box_x_q, box_x_d, box_y_q, box_y_d;
    logic                  dx_q, dx_d, dy_q, dy_d;   // 1 = moving +, 0 = moving -
    // Combinational helpers
    logic                  w_frame_tick;
    logic [CNT_W-1:0]      w_bar_full;
    logic [2:0]            w_bar;
    logic [BW-1:0]         w_px, w_py;
    logic                  w_in_box;
    logic [COLOR_BITS-1:0] w_r, w_g, w_b;

    // First line of vertical blanking marks the frame boundary
    assign w_frame_tick = (bus.h_count == '0) && (bus.v_count == c_tick_line);
    assign w_btn_rise   = btn_sync_q & ~btn_prev_q;

    // Two-flop synchroniser for the asynchronous button, plus previous level
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            btn_meta_q <= 1'b0;
            btn_sync_q <= 1'b0;
            btn_prev_q <= 1'b0;
        end else begin
            btn_meta_q <= bus.button;
            btn_sync_q <= btn_meta_q;
            btn_prev_q <= btn_sync_q;
        end
    end

    // Next-state for mode, pending press, frame counter and box motion
    always_comb begin
        mode_d      = mode_q;
        frame_cnt_d = frame_cnt_q;
        box_x_d     = box_x_q;
        box_y_d     = box_y_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        // An edge on the tick cycle itself survives the clear and waits a frame
        pending_d   = (pending_q & ~w_frame_tick) | w_btn_rise;
        if (w_frame_tick) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            if (pending_q) begin
                mode_d = (mode_q == c_mode_last) ? 3'd0 : mode_q + 3'd1;
            end
            if (dx_q) begin
                if (box_x_q + c_box_step + c_box_size >= c_h_active) begin
                    box_x_d = c_h_limit;
                    dx_d    = 1'b0;
                end else begin
                    box_x_d = box_x_q + c_box_step;
                end
            end else begin
                if (box_x_q < c_box_step) begin
                    box_x_d = '0;
                    dx_d    = 1'b1;
                end else begin
                    box_x_d = box_x_q - c_box_step;
                end
            end
            if (dy_q) begin
                if (box_y_q + c_box_step + c_box_size >= c_v_active) begin
                    box_y_d = c_v_limit;
                    dy_d    = 1'b0;
                end else begin
                    box_y_d = box_y_q + c_box_step;
                end
            end else begin
                if (box_y_q < c_box_step) begin
                    box_y_d = '0;
                    dy_d    = 1'b1;
                end else begin
                    box_y_d = box_y_q - c_box_step;
                end
            end
        end
    end

    // Frame-rate control state registers
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            mode_q      <= 3'd0;
            pending_q   <= 1'b0;
            frame_cnt_q <= 16'd0;
            box_x_q     <= '0;
            box_y_q     <= '0;
            dx_q        <= 1'b1;
            dy_q        <= 1'b1;
        end else begin
            mode_q      <= mode_d;
            pending_q   <= pending_d;
            frame_cnt_q <= frame_cnt_d;
            box_x_q     <= box_x_d;
            box_y_q     <= box_y_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
        end
    end

    // Stage 1: capture raster position, display enable and syncs
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            h1_q  <= '0;
            v1_q  <= '0;
            de1_q <= 1'b0;
            hs1_q <= 1'b0;
            vs1_q <= 1'b0;
        end else begin
            h1_q  <= bus.h_count;
            v1_q  <= bus.v_count;
            de1_q <= bus.display_en;
            hs1_q <= bus.h_sync_in;
            vs1_q <= bus.v_sync_in;
        end
    end

    // Pixel colour from stage-1 position; blanked outside the visible area
    always_comb begin
        w_r        = '0;
        w_g        = '0;
        w_b        = '0;
        w_bar_full = h1_q / c_bar_w;
        w_bar      = (w_bar_full > c_last_bar) ? 3'd7 : w_bar_full[2:0];
        w_px       = {1'b0, h1_q};
        w_py       = {1'b0, v1_q};
        w_in_box   = (w_px >= box_x_q) && (w_px < box_x_q + c_box_size) &&
                     (w_py >= box_y_q) && (w_py < box_y_q + c_box_size);
        if (de1_q) begin
            case (mode_q)
                // Bar order white,yellow,cyan,green,magenta,red,blue,black
                // maps to r=~idx[1], g=~idx[2], b=~idx[0]
                3'd0: begin
                    w_r = {COLOR_BITS{~w_bar[1]}};
                    w_g = {COLOR_BITS{~w_bar[2]}};
                    w_b = {COLOR_BITS{~w_bar[0]}};
                end
                3'd1: begin
                    if (h1_q[CHECK_LOG2] ^ v1_q[CHECK_LOG2]) begin
                        w_r = c_full;
                        w_g = c_full;
                        w_b = c_full;
                    end
                end
                3'd2: begin
                    w_r = h1_q[CNT_W-1 -: COLOR_BITS];
                    w_g = h1_q[CNT_W-1 -: COLOR_BITS];
                    w_b = h1_q[CNT_W-1 -: COLOR_BITS];
                end
                3'd3: begin
                    w_b = c_full;
                    if (w_in_box) begin
                        w_r = c_full;
                        w_g = c_full;
                    end
                end
                3'd4: begin
                    w_r = c_full;
                    w_g = c_full;
                    w_b = c_full;
                end
                default: begin
                    w_r = '0;
                    w_g = '0;
                    w_b = '0;
                end
            endcase
        end
    end

    // Stage 2: register colour and the second sync delay
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_q   <= '0;
            g_q   <= '0;
            b_q   <= '0;
            hs2_q <= 1'b0;
            vs2_q <= 1'b0;
        end else begin
            r_q   <= w_r;
            g_q   <= w_g;
            b_q   <= w_b;
            hs2_q <= hs1_q;
            vs2_q <= vs1_q;
        end
    end

    assign bus.r         = r_q;
    assign bus.g         = g_q;
    assign bus.b         = b_q;
    assign bus.h_sync    = hs2_q;
    assign bus.v_sync    = vs2_q;
    assign bus.mode      = mode_q;
    assign bus.frame_cnt = frame_cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_vga_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_pattern_gen
// Description : Self-checking bench for vga_pattern_gen (COLOR_BITS=4).
//               Every cycle is compared against an arithmetic reference model;
//               table vectors and directed sequences cover the corner cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_pattern_gen;
    localparam int CB = 4, CW = 10, HA = 640, VA = 480, CL = 5, BS = 64, BST = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_pattern_gen_if #(.COLOR_BITS(CB), .CNT_W(CW)) vif();

    vga_pattern_gen #(
        .COLOR_BITS(CB), .CNT_W(CW), .H_ACTIVE(HA), .V_ACTIVE(VA),
        .CHECK_LOG2(CL), .BOX_SIZE(BS), .BOX_STEP(BST)
    ) dut (
        .clk_sys (clk),
        .reset   (rst),
        .bus     (vif)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_mode, m_fc, m_bx, m_by, m_dx, m_dy;
    bit m_pend;
    bit bh1, bh2, bh3;                 // button levels seen at the last three edges
    int p_h, p_v;                      // inputs seen at the previous edge
    bit p_de, p_hs, p_vs;
    logic [11:0] e_rgb;
    bit e_hs, e_vs;

    typedef struct {
        int          mode;
        int          h;
        int          v;
        bit          de;
        logic [11:0] rgb;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] bar_rgb(input int idx);
        case (idx)
            0:       return 3'b111;   // white
            1:       return 3'b110;   // yellow
            2:       return 3'b011;   // cyan
            3:       return 3'b010;   // green
            4:       return 3'b101;   // magenta
            5:       return 3'b100;   // red
            6:       return 3'b001;   // blue
            default: return 3'b000;   // black
        endcase
    endfunction

    function automatic logic [11:0] colour(input int h, input int v, input bit de,
                                           input int mode, input int bx, input int by);
        logic [2:0] c;
        logic [3:0] lvl;
        if (!de) return 12'h000;
        case (mode)
            0: begin
                c = bar_rgb(h / (HA / 8));
                return {{4{c[2]}}, {4{c[1]}}, {4{c[0]}}};
            end
            1: return ((((h / (1 << CL)) + (v / (1 << CL))) % 2) == 1) ? 12'hFFF : 12'h000;
            2: begin
                lvl = 4'(h / (1 << (CW - CB)));
                return {lvl, lvl, lvl};
            end
            3: return (h >= bx && h < bx + BS && v >= by && v < by + BS) ? 12'hFFF : 12'h00F;
            4: return 12'hFFF;
            default: return 12'h000;
        endcase
    endfunction

    task automatic m_reset();
        m_mode = 0; m_fc = 0; m_bx = 0; m_by = 0; m_dx = 1; m_dy = 1; m_pend = 1'b0;
        bh1 = 1'b0; bh2 = 1'b0; bh3 = 1'b0;
        p_h = 0; p_v = 0; p_de = 1'b0; p_hs = 1'b0; p_vs = 1'b0;
        e_rgb = 12'h000; e_hs = 1'b0; e_vs = 1'b0;
    endtask

    // One clock: advance the model with the inputs present at the edge, then compare
    task automatic step();
        int ch, cv;
        bit cde, chs, cvs, cbtn, tick, edg;
        ch = int'(vif.h_count); cv = int'(vif.v_count);
        cde = vif.display_en; chs = vif.h_sync_in; cvs = vif.v_sync_in; cbtn = vif.button;
        @(posedge clk);
        #1;
        if (rst) begin
            m_reset();
        end else begin
            e_rgb = colour(p_h, p_v, p_de, m_mode, m_bx, m_by);
            e_hs  = p_hs;
            e_vs  = p_vs;
            tick  = (ch == 0) && (cv == VA);
            edg   = bh2 && !bh3;
            if (tick) begin
                m_fc = (m_fc + 1) % 65536;
                if (m_pend) m_mode = (m_mode == 4) ? 0 : m_mode + 1;
                if (m_dx > 0) begin
                    if (m_bx + BST + BS >= HA) begin m_bx = HA - BS; m_dx = -1; end
                    else m_bx = m_bx + BST;
                end else begin
                    if (m_bx < BST) begin m_bx = 0; m_dx = 1; end
                    else m_bx = m_bx - BST;
                end
                if (m_dy > 0) begin
                    if (m_by + BST + BS >= VA) begin m_by = VA - BS; m_dy = -1; end
                    else m_by = m_by + BST;
                end else begin
                    if (m_by < BST) begin m_by = 0; m_dy = 1; end
                    else m_by = m_by - BST;
                end
            end
            m_pend = (m_pend && !tick) || edg;
            bh3 = bh2; bh2 = bh1; bh1 = cbtn;
            p_h = ch; p_v = cv; p_de = cde; p_hs = chs; p_vs = cvs;
        end
        chk("rgb",       {vif.r, vif.g, vif.b}, e_rgb);
        chk("h_sync",    vif.h_sync, e_hs);
        chk("v_sync",    vif.v_sync, e_vs);
        chk("mode",      vif.mode, m_mode);
        chk("frame_cnt", vif.frame_cnt, m_fc);
    endtask

    task automatic tick();
        vif.h_count = '0; vif.v_count = CW'(VA); vif.display_en = 1'b0;
        step();
        vif.h_count = CW'(5); vif.v_count = CW'(10);
    endtask

    task automatic press();
        vif.button = 1'b1;
        repeat (3) step();
        vif.button = 1'b0;
        repeat (3) step();
    endtask

    task automatic probe(input string nm, input int h, input int v, input logic [11:0] exp);
        vif.h_count = CW'(h); vif.v_count = CW'(v); vif.display_en = 1'b1;
        step();
        step();
        chk(nm, {vif.r, vif.g, vif.b}, exp);
        vif.display_en = 1'b0;
    endtask

    task automatic run_vecs(input int mode);
        foreach (vecs[i]) begin
            if (vecs[i].mode == mode) begin
                vif.h_count = CW'(vecs[i].h); vif.v_count = CW'(vecs[i].v);
                vif.display_en = vecs[i].de;
                step();
                step();
                chk($sformatf("vec_m%0d_h%0d", mode, vecs[i].h), {vif.r, vif.g, vif.b}, vecs[i].rgb);
            end
        end
        vif.display_en = 1'b0;
    endtask

    initial begin
        vecs.push_back('{0,   0, 10, 1'b1, 12'hFFF});
        vecs.push_back('{0,  79, 10, 1'b1, 12'hFFF});
        vecs.push_back('{0,  80, 10, 1'b1, 12'hFF0});
        vecs.push_back('{0, 160, 10, 1'b1, 12'h0FF});
        vecs.push_back('{0, 240, 10, 1'b1, 12'h0F0});
        vecs.push_back('{0, 320, 10, 1'b1, 12'hF0F});
        vecs.push_back('{0, 400, 10, 1'b1, 12'hF00});
        vecs.push_back('{0, 480, 10, 1'b1, 12'h00F});
        vecs.push_back('{0, 600, 10, 1'b1, 12'h000});
        vecs.push_back('{0, 700, 10, 1'b0, 12'h000});
        vecs.push_back('{1,  32,  0, 1'b1, 12'hFFF});
        vecs.push_back('{1,   0,  0, 1'b1, 12'h000});
        vecs.push_back('{1,  32, 32, 1'b1, 12'h000});
        vecs.push_back('{1,   0, 32, 1'b1, 12'hFFF});
        vecs.push_back('{2,   0,  5, 1'b1, 12'h000});
        vecs.push_back('{2,  64,  5, 1'b1, 12'h111});
        vecs.push_back('{2, 639,  5, 1'b1, 12'h999});
        vecs.push_back('{2, 700,  5, 1'b0, 12'h000});

        vif.h_count = CW'(5); vif.v_count = CW'(10); vif.display_en = 1'b0;
        vif.h_sync_in = 1'b1; vif.v_sync_in = 1'b1; vif.button = 1'b0;
        m_reset();

        // Reset state
        rst = 1'b1;
        repeat (3) step();
        chk("reset_rgb", {vif.r, vif.g, vif.b}, 12'h000);
        chk("reset_hsync", vif.h_sync, 1'b0);
        chk("reset_mode", vif.mode, 3'd0);
        chk("reset_fc", vif.frame_cnt, 16'd0);
        rst = 1'b0;
        repeat (2) step();

        // h_sync delayed exactly two cycles
        vif.h_sync_in = 1'b0;
        step();
        chk("hsync_d1", vif.h_sync, 1'b1);
        vif.h_sync_in = 1'b1;
        step();
        chk("hsync_d2", vif.h_sync, 1'b0);
        step();
        chk("hsync_d3", vif.h_sync, 1'b1);

        run_vecs(0);

        // Two presses in one frame advance the mode once
        press();
        press();
        tick();
        chk("two_press_tick1", vif.mode, 3'd1);
        tick();
        chk("two_press_tick2", vif.mode, 3'd1);
        run_vecs(1);

        press();
        tick();
        chk("mode2", vif.mode, 3'd2);
        run_vecs(2);

        press();
        tick();
        chk("mode3", vif.mode, 3'd3);

        // Bouncing box over ~300 frames
        while (m_fc < 300) begin
            tick();
            probe("box_in",  m_bx, m_by, 12'hFFF);
            probe("box_out", m_bx + BS, m_by, 12'h00F);
            if (m_fc == 288) begin
                probe("box_x_peak",    576, 256, 12'hFFF);
                probe("box_left_out",  575, 256, 12'h00F);
                probe("box_top_out",   576, 255, 12'h00F);
            end
            if (m_fc == 289) begin
                probe("box_x_back",    574, 254, 12'hFFF);
                probe("box_back_out",  573, 254, 12'h00F);
            end
        end

        // Edge landing on the frame_tick cycle waits for the next tick
        vif.button = 1'b1;
        step();
        step();
        tick();
        chk("edge_on_tick", vif.mode, 3'd3);
        vif.button = 1'b0;
        repeat (3) step();
        tick();
        chk("edge_next_tick", vif.mode, 3'd4);
        press();
        tick();
        chk("mode_wrap", vif.mode, 3'd0);

        // Asynchronous reset in the middle of a line at frame 37
        rst = 1'b1;
        step();
        rst = 1'b0;
        press();
        while (m_fc < 37) tick();
        probe("pre_reset_px", 32, 0, 12'hFFF);
        vif.h_count = CW'(32); vif.v_count = CW'(0); vif.display_en = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("async_fc",   vif.frame_cnt, 16'd0);
        chk("async_mode", vif.mode, 3'd0);
        chk("async_rgb",  {vif.r, vif.g, vif.b}, 12'h000);
        chk("async_hs",   vif.h_sync, 1'b0);
        step();
        rst = 1'b0;
        vif.h_count = CW'(0); vif.v_count = CW'(10); vif.display_en = 1'b1;
        step();
        chk("post_reset_1", {vif.r, vif.g, vif.b}, 12'h000);
        step();
        chk("post_reset_2", {vif.r, vif.g, vif.b}, 12'hFFF);

        // Randomised traffic with occasional frame ticks and button activity
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(24) == 0) begin
                vif.h_count = '0; vif.v_count = CW'(VA); vif.display_en = 1'b0;
            end else begin
                vif.h_count = CW'($urandom_range(799));
                vif.v_count = CW'($urandom_range(524));
                vif.display_en = (vif.h_count < CW'(HA)) && (vif.v_count < CW'(VA));
            end
            vif.h_sync_in = 1'($urandom_range(1));
            vif.v_sync_in = 1'($urandom_range(1));
            if ($urandom_range(7) == 0) vif.button = ~vif.button;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/vga_pattern_gen.md
Name: vga_pattern_gen

Overview:
- Parametrised VGA test-pattern generator; sits after vga_sync in the clk_sys domain.
- Consumes h_count, v_count, display_en and the sync signals from vga_sync.
- Produces registered, width-configurable RGB with sync outputs delayed to match the RGB path.
- Provides selectable patterns (colour bars, checkerboard, gradient, bouncing box, solid), a button-driven mode cycler applied on frame boundaries, and a frame counter.

Parameters:
COLOR_BITS, 1, bits per colour channel (1..8)
CNT_W, 10, width of h_count/v_count
H_ACTIVE, 640, visible pixels per line
V_ACTIVE, 480, visible lines per frame
CHECK_LOG2, 5, checkerboard cell size = 2^CHECK_LOG2 pixels
BOX_SIZE, 64, bouncing box edge length in pixels
BOX_STEP, 2, box displacement per frame on each axis

Ports:
clk_sys  in  1  pixel clock (25.125 MHz from PLL)
reset  in  1  asynchronous, active-high reset
h_count  in  CNT_W  horizontal position from vga_sync
v_count  in  CNT_W  vertical position from vga_sync
display_en  in  1  high inside the visible area
h_sync_in  in  1  horizontal sync from vga_sync
v_sync_in  in  1  vertical sync from vga_sync
button  in  1  asynchronous mode-advance button, active-high
r  out  COLOR_BITS  red
g  out  COLOR_BITS  green
b  out  COLOR_BITS  blue
h_sync  out  1  h_sync_in delayed 2 cycles
v_sync  out  1  v_sync_in delayed 2 cycles
mode  out  3  current pattern mode
frame_cnt  out  16  frames since reset, wraps 0xFFFF->0

Behaviour:
- Reset (asynchronous, active-high) values: r=g=b=0, h_sync=v_sync=0, mode=0, frame_cnt=0, box_x=box_y=0, dx=dy=+1, pending=0, synchroniser flops=0.
- Pipeline latency is 2 cycles from inputs to r/g/b/h_sync/v_sync.
  - Stage 1 registers counts, display_en and syncs.
  - Stage 2 registers colour.
  - Sync outputs use an identical 2-flop delay.
- Blanking: stage-2 colour is 0 whenever the delayed display_en is 0.
- "Full" means all channel bits = 1; "0" means all bits = 0.
- frame_tick: 1-cycle pulse when h_count==0 and v_count==V_ACTIVE (first blanking line).
  - frame_cnt increments on frame_tick.
  - Box position and mode update only on frame_tick.
- Button handling:
  - 2-FF synchroniser followed by a rising-edge detector.
  - A rising edge sets pending.
  - On frame_tick with pending=1: mode <= (mode==4) ? 0 : mode+1, and pending is cleared.
  - An edge arriving on the same cycle as frame_tick stays pending for the next tick.
  - Multiple edges within one frame produce a single increment.
- Mode 0, colour bars: 8 equal bars of H_ACTIVE/8 pixels, left to right: white, yellow, cyan, green, magenta, red, blue, black.
- Mode 1, checkerboard: full white when h_count[CHECK_LOG2] XOR v_count[CHECK_LOG2] = 1, else black.
- Mode 2, gradient: r=g=b = h_count[CNT_W-1 -: COLOR_BITS].
- Mode 3, bouncing box:
  - Pixels with box_x <= h < box_x+BOX_SIZE and box_y <= v < box_y+BOX_SIZE are full white.
  - All other pixels are full blue only.
- Mode 4: solid full white.
- Modes 5-7: unreachable via button; output black if forced.
- Box update on frame_tick, per axis (x shown; y identical with V_ACTIVE):
  - dx=+1: if box_x+BOX_STEP+BOX_SIZE >= H_ACTIVE then box_x <= H_ACTIVE-BOX_SIZE and dx <= -1; else box_x += BOX_STEP.
  - dx=-1: if box_x < BOX_STEP then box_x <= 0 and dx <= +1; else box_x -= BOX_STEP.
  - The box updates in every mode, so its position is continuous when mode 3 is entered.
- Arithmetic: box coordinates are CNT_W+1 bits internally to avoid overflow in the comparisons.
- Reset mid-frame: all state returns to reset values immediately; output is valid again 2 cycles after reset deassertion.

Test Plan:
- Reset, then run 1 frame in mode 0 -> at pixel (0,10) RGB=white; at (80,10) yellow; at (600,10) black; output appears 2 cycles after the counts; h_sync equals h_sync_in delayed exactly 2 cycles.
- Pulse button twice in frame 0 -> mode 0->1 at the first frame_tick only; pixel (32,0)=white, (0,0)=black, (32,32)=black.
- Set COLOR_BITS=4, mode 2 -> h=0 gives 0x0, h=64 gives 0x1, h=639 gives 0x9; display_en=0 at h=700 gives 0.
- Mode 3, 300 frames -> box_x after frame n = 2n until 576; at 576 dx flips and the next value is 574; box_y reverses at 416; pixel (box_x,box_y)=white, (box_x+64,box_y)=blue.
- Button edge exactly on the frame_tick cycle -> mode unchanged at that tick, increments at the following tick; mode 4 + press -> 0.
- Assert reset mid-line at frame_cnt=37 -> frame_cnt, mode, box and outputs go to 0 / start values immediately, without waiting for a clock edge.
